// File: rtl/mips_mon_pkg.sv
// Shared types and constants for the MIPS retire monitor.
package mips_mon_pkg;

    // Monitor lifecycle: wait for en, watch the core, then park in a terminal state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_TOUT = 2'd3
    } mon_state_t;

    // Opcode of the MIPS J instruction.
    localparam logic [5:0] OPC_J = 6'b000010;

    // One trace entry as it appears on trc_data for the default 32-bit datapath.
    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } trc_entry_t;

    // A J whose 26-bit word target equals the current pc word index jumps to itself,
    // which is the program's way of saying "finished".
    function automatic logic is_jump_self(input logic [31:0] instr,
                                          input logic [25:0] pc_word);
        return (instr[31:26] == OPC_J) && (instr[25:0] == pc_word);
    endfunction

endpackage

// File: rtl/mips_trace_fifo.sv
// Small register-based FIFO holding register-file writes until the consumer takes them.
// Pointers carry one extra wrap bit so full and empty fall out of a plain compare.
module mips_trace_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             ovf_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             pop;
    logic             wr_en;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = !empty && ready_i;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
    assign wr_en   = push_i && (!full_o || pop);
    assign ovf_o   = push_i && full_o && !pop;
    assign valid_o = !empty;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted pushes and pops.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; cleared on reset so trc_data reads zero while empty after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/mips_retire_monitor.sv
// End-of-test monitor for the single-cycle MIPS core: halt detection, one-register
// pass check, cycle timeout, retire count and a trace FIFO of register writes.
module mips_retire_monitor
    import mips_mon_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [4:0]       CHECK_REG   = 5'd3,
    parameter logic [XLEN-1:0]  CHECK_VAL   = 32'h1,
    parameter int               TIMEOUT_CYC = 20,
    parameter int               FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [XLEN-1:0]   pc,
    input  logic [31:0]       instr,
    input  logic              rf_we,
    input  logic [4:0]        rf_waddr,
    input  logic [XLEN-1:0]   rf_wdata,
    output logic              trc_valid,
    input  logic              trc_ready,
    output logic [5+XLEN-1:0] trc_data,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       retired,
    output logic              drop
);
    localparam int            CW       = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT_CYC - 1);

    mon_state_t      state_q, state_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            timeout_q, timeout_d;
    logic            drop_q, drop_d;
    logic [15:0]     retired_q, retired_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [XLEN-1:0] shadow_q, shadow_d;

    logic in_run;
    logic halt_hit;
    logic chk_wr;
    logic push;
    logic fifo_full;
    logic fifo_ovf;

    // pc bits outside the J target field play no part in the halt compare.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[XLEN-1:28], pc[1:0]};

    assign in_run   = (state_q == ST_RUN);
    assign halt_hit = is_jump_self(instr, pc[27:2]);
    // r0 is hardwired zero in the core, so its writes are neither traced nor shadowed.
    assign chk_wr   = rf_we && (rf_waddr == CHECK_REG) && (rf_waddr != 5'd0);
    assign push     = in_run && rf_we && (rf_waddr != 5'd0);

    mips_trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (5 + XLEN)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  ({rf_waddr, rf_wdata}),
        .ready_i (trc_ready),
        .valid_o (trc_valid),
        .data_o  (trc_data),
        .full_o  (fifo_full),
        .ovf_o   (fifo_ovf)
    );

    // Next-state logic: FSM transitions, counters, shadow register and sticky flags.
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        retired_d = retired_q;
        cyc_d     = cyc_q;
        shadow_d  = shadow_q;
        drop_d    = drop_q | fifo_ovf;

        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
                cyc_d = cyc_q + 1'b1;
                if (chk_wr) shadow_d = rf_wdata;
                // Halt is checked first so it wins over a coincident timeout; the
                // comparison uses the post-write shadow so a same-cycle write counts.
                if (halt_hit) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
                    pass_d  = (shadow_d == CHECK_VAL);
                end else if (cyc_q == CYC_LAST) begin
                    state_d   = ST_TOUT;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            drop_q    <= 1'b0;
            retired_q <= '0;
            cyc_q     <= '0;
            shadow_q  <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
            retired_q <= retired_d;
            cyc_q     <= cyc_d;
            shadow_q  <= shadow_d;
        end
    end

    assign done    = done_q;
    assign pass    = pass_q;
    assign timeout = timeout_q;
    assign retired = retired_q;
    assign drop    = drop_q;

endmodule

// File: tb/tb_mips_retire_monitor.sv
// Randomized bench for mips_retire_monitor against a queue-based behavioural model.
module tb_mips_retire_monitor;
    import mips_mon_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        trc_valid;
    logic        trc_ready;
    logic [36:0] trc_data;
    logic        done, pass, timeout, drop;
    logic [15:0] retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_retire_monitor dut (
        .clk       (clk),
        .reset     (reset_n),
        .en        (en),
        .pc        (pc),
        .instr     (instr),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .trc_valid (trc_valid),
        .trc_ready (trc_ready),
        .trc_data  (trc_data),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .retired   (retired),
        .drop      (drop)
    );

    // Behavioural model: mode 0 idle, 1 running, 2 halted, 3 timed out.
    int          m_mode;
    int          m_ret;
    int          m_cyc;
    int          m_pops;
    logic        m_done, m_pass, m_tout, m_drop;
    logic [31:0] m_shadow;
    logic [36:0] m_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ret = 0; m_cyc = 0; m_pops = 0;
        m_done = 0; m_pass = 0; m_tout = 0; m_drop = 0;
        m_shadow = 0;
        m_q.delete();
    endtask

    task automatic idle_inputs();
        en = 0; pc = 0; instr = 32'h0000_0020; rf_we = 0; rf_waddr = 0; rf_wdata = 0;
    endtask

    task automatic compare_all();
        trc_entry_t e;
        chk("valid", trc_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("data", trc_data, m_q[0]);
        chk("done", done, m_done);
        chk("pass", pass, m_pass);
        chk("timeout", timeout, m_tout);
        chk("retired", retired, m_ret);
        chk("drop", drop, m_drop);
        e = trc_data;
        if (e.waddr === 5'd31 && trc_valid === 1'bx) $display("note x on valid");
    endtask

    // One clock with the currently driven inputs; model advances alongside the DUT.
    task automatic cycle();
        logic        do_pop, do_push, is_halt;
        logic [31:0] nsh;
        do_pop  = (m_q.size() != 0) && trc_ready;
        do_push = (m_mode == 1) && rf_we && (rf_waddr != 0);
        is_halt = (instr[31:26] == 6'b000010) && (instr[25:0] == pc[27:2]);
        @(posedge clk);
        if (m_mode == 0) begin
            if (en) m_mode = 1;
        end else if (m_mode == 1) begin
            nsh = (rf_we && rf_waddr == 5'd3) ? rf_wdata : m_shadow;
            m_ret = (m_ret < 65535) ? m_ret + 1 : 65535;
            m_cyc++;
            m_shadow = nsh;
            if (is_halt) begin
                m_mode = 2; m_done = 1; m_pass = (nsh == 32'h1);
            end else if (m_cyc == 20) begin
                m_mode = 3; m_tout = 1; m_pass = 0;
            end
        end
        if (do_pop) begin
            $display("pop r%0d=%08h", m_q[0][36:32], m_q[0][31:0]);
            void'(m_q.pop_front());
            m_pops++;
        end
        if (do_push) begin
            if (m_q.size() < 4) m_q.push_back({rf_waddr, rf_wdata});
            else m_drop = 1;
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle_inputs();
        trc_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset_n = 1;
    endtask

    task automatic start_run();
        en = 1;
        cycle();
        en = 0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        rf_we = 1; rf_waddr = 5'(a); rf_wdata = d;
    endtask

    // Directed program: r1=5, r2=5, r3=v, halt at pc 0x14.
    task automatic halt_prog(input logic [31:0] r3v);
        for (int i = 0; i < 6; i++) begin
            pc = 32'(i * 4);
            instr = (i == 5) ? 32'h0800_0005 : 32'h0000_0020;
            rf_we = 0;
            if (i == 0) wr(1, 5);
            if (i == 1) wr(2, 5);
            if (i == 2) wr(3, r3v);
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        trc_ready = 0;
        do_reset();
        compare_all();
        chk("rst_data", trc_data, 37'd0);

        // Passing program
        trc_ready = 1;
        start_run();
        halt_prog(32'h1);
        chk("p_done", done, 1);
        chk("p_pass", pass, 1);
        chk("p_tout", timeout, 0);
        chk("p_ret", retired, 6);
        repeat (4) cycle();
        chk("p_ret_frozen", retired, 6);

        // Failing program
        do_reset();
        trc_ready = 1;
        start_run();
        halt_prog(32'h0);
        chk("f_done", done, 1);
        chk("f_pass", pass, 0);

        // Timeout
        do_reset();
        trc_ready = 1;
        start_run();
        for (int i = 0; i < 25; i++) begin
            pc = 32'(i * 4); instr = 32'h0000_0020;
            rf_we = $urandom_range(0, 1); rf_waddr = 5'($urandom_range(0, 7));
            rf_wdata = $urandom;
            trc_ready = $urandom_range(0, 1);
            cycle();
        end
        idle_inputs();
        chk("t_tout", timeout, 1);
        chk("t_ret", retired, 20);
        chk("t_done", done, 0);

        // Overflow with consumer stalled, then drain in order
        do_reset();
        start_run();
        for (int i = 1; i <= 6; i++) begin
            pc = 32'(i * 4); wr(i, $urandom);
            cycle();
        end
        idle_inputs();
        chk("o_drop", drop, 1);
        trc_ready = 1;
        repeat (6) cycle();
        chk("o_pops", m_pops, 4);
        chk("o_empty", trc_valid, 0);

        // Full FIFO with simultaneous push and pop; r0 write ignored
        do_reset();
        start_run();
        for (int i = 1; i <= 4; i++) begin
            pc = 32'(i * 4); wr(i, $urandom);
            cycle();
        end
        trc_ready = 1;
        for (int i = 5; i <= 7; i++) begin
            pc = 32'(i * 4); wr(i, $urandom);
            cycle();
            chk("pp_occ", m_q.size(), 4);
        end
        chk("pp_drop", drop, 0);
        trc_ready = 0;
        pc = 32'h40; wr(0, 32'h1);
        cycle();
        chk("r0_drop", drop, 0);
        chk("r0_occ", m_q.size(), 4);
        pc = 32'h44; instr = 32'h0800_0011; rf_we = 0;
        cycle();
        chk("r0_pass", pass, 0);
        idle_inputs();

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < 30; i++) begin
                en = $urandom_range(0, 3) == 0;
                pc = 32'(i * 4);
                instr = ($urandom_range(0, 9) == 0) ? {6'b000010, pc[27:2]} : $urandom;
                rf_we = $urandom_range(0, 1);
                rf_waddr = 5'($urandom_range(0, 7));
                rf_wdata = 32'($urandom_range(0, 2));
                trc_ready = $urandom_range(0, 2) != 0;
                cycle();
            end
            idle_inputs();
        end

        // Asynchronous reset in the middle of a run
        do_reset();
        start_run();
        pc = 32'h0; wr(1, 32'hA);
        cycle();
        pc = 32'h4; wr(2, 32'hB);
        cycle();
        idle_inputs();
        chk("ar_valid_pre", trc_valid, 1);
        #2 reset_n = 0;
        #1;
        chk("ar_valid", trc_valid, 0);
        chk("ar_ret", retired, 0);
        chk("ar_data", trc_data, 37'd0);
        chk("ar_flags", {done, pass, timeout, drop}, 4'b0000);
        @(posedge clk);
        #1 reset_n = 1;
        model_reset();
        trc_ready = 1;
        pc = 32'h8; instr = 32'h0800_0002;
        repeat (3) cycle();
        chk("ar_idle_done", done, 0);
        start_run();
        cycle();
        chk("ar_run_done", done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_retire_monitor.md
# mips_retire_monitor

Synthesizable end-of-test monitor sitting directly downstream of the single-cycle MIPS top: samples the PC, current instruction and register-file write port every cycle, detects the jump-to-self halt, checks one architectural register against an expected value, and enforces a cycle timeout. Also buffers register writes in a small trace FIFO drained over a valid/ready port. Replaces hand-written halt/pass/timeout logic in benches and provides the same status to on-board debug.

## Interface
- XLEN, 32, datapath width
- CHECK_REG, 3, register index compared at halt
- CHECK_VAL, 32'h1, expected value of CHECK_REG
- TIMEOUT_CYC, 20, RUN cycles before timeout (≥2)
- FIFO_DEPTH, 4, trace entries (power of 2)

- clk  in  1  core clock
- reset  in  1  asynchronous, active-low; all state cleared while low
- en  in  1  start monitoring (level, sampled in IDLE only)
- pc  in  XLEN  CPU program counter
- instr  in  32  instruction at pc
- rf_we  in  1  register-file write enable
- rf_waddr  in  5  write address
- rf_wdata  in  XLEN  write data
- trc_valid  out  1  trace entry available
- trc_ready  in  1  consumer accepts entry
- trc_data  out  5+XLEN  {waddr, wdata}
- done  out  1  halt detected (sticky)
- pass  out  1  shadow CHECK_REG == CHECK_VAL at halt (sticky)
- timeout  out  1  TIMEOUT_CYC reached without halt (sticky)
- retired  out  16  instructions retired in RUN, saturating at 16'hFFFF
- drop  out  1  trace entry lost to full FIFO (sticky)

## Operation
- States: IDLE, RUN, HALT, TOUT. Reset → IDLE.
- IDLE → RUN when en=1. en ignored in all other states.
- RUN, each cycle: retired += 1 (saturating); cycle counter += 1.
- Halt instruction: instr[31:26]==6'b000010 and instr[25:0]==pc[27:2]. In RUN → HALT; done=1; pass = (shadow == CHECK_VAL).
- Timeout: cycle counter == TIMEOUT_CYC−1 with no halt → TOUT; timeout=1, pass=0.
- Halt and timeout in same cycle: halt wins.
- HALT, TOUT terminal until reset; no counting, no FIFO pushes.
- Shadow register: XLEN bits, reset 0; loaded with rf_wdata when RUN and rf_we and rf_waddr==CHECK_REG. A write to CHECK_REG in the same cycle as halt is included in the comparison (compare against the next-shadow value).
- Writes to register 0 never pushed and never update shadow.
- FIFO push: RUN and rf_we and rf_waddr≠0. Pop: trc_valid and trc_ready.
- Full with push and no pop: entry discarded, drop=1. Full with push and pop: both occur, no drop.
- Empty: trc_valid=0, trc_data don't-care. trc_data held stable while trc_valid and not trc_ready.
- FIFO keeps draining in HALT/TOUT.

## Timing
- All outputs registered; reset values: trc_valid=0, done=0, pass=0, timeout=0, retired=0, drop=0, trc_data=0.
- done/pass/timeout assert on the clock edge that samples the triggering cycle (visible 1 cycle after the halt instruction is presented).
- Push→trc_valid latency 1 cycle; no bypass of an empty FIFO.
- Throughput: 1 push and 1 pop per cycle.
- Reset low mid-RUN: immediately clears state, counters, FIFO pointers and sticky flags.

## Structure
- Package mips_mon_pkg: state enum, OPC_J=6'b000010, trace entry struct {waddr, wdata}.
- One sub-module: mips_trace_fifo (parameterized depth/width, pointers with extra wrap bit, full/empty from pointer compare).
- Top holds FSM, counters, shadow register, halt decode.

## Test plan
- en=1; writes r1=5, r2=5, r3=1; at pc=0x14 instr=0x08000005 → done=1, pass=1, timeout=0, retired=6 with halt at sixth RUN cycle.
- Same sequence with r3=0 written → done=1, pass=0.
- No halt instruction, TIMEOUT_CYC=20 → timeout=1 after 20 RUN cycles, retired=20, done=0.
- trc_ready=0, six writes to r1..r6 → 4 entries held, drop=1; then trc_ready=1 → entries {1,d1}..{4,d4} in order, trc_valid falls after 4 pops.
- Full FIFO, simultaneous push and pop → no drop, occupancy stays 4; write to r0 → no push, shadow unchanged.
- Assert reset low mid-RUN with 2 FIFO entries → all outputs 0 asynchronously; after release state IDLE until en.
